// File: rtl/bus_arb_pkg.sv
// Shared types for the serial-bus grant scheduler.
// Holds the arbiter state encoding and the bus mux select codes.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    GRANT_I0    = 2'b01,
    GRANT_I1    = 2'b10,
    GRANT_SPLIT = 2'b11
  } arb_state_t;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_I0    = 2'b01;
  localparam logic [1:0] SEL_I1    = 2'b10;
  localparam logic [1:0] SEL_SPLIT = 2'b11;

  function automatic logic [1:0] sel_of(
    input arb_state_t s
  );
    logic [1:0] r;
    r = SEL_NONE;
    unique case (s)
      IDLE:        r = SEL_NONE;
      GRANT_I0:    r = SEL_I0;
      GRANT_I1:    r = SEL_I1;
      GRANT_SPLIT: r = SEL_SPLIT;
      default:     r = SEL_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// Saturating hold-time counter for the bus arbiter watchdog.
// Ports: clk, rst_n, clr_i (zero count), en_i (count a granted cycle), expire_o.
module arb_hold_timer #(
  parameter int unsigned HOLD_MAX = 256,
  parameter int unsigned CNT_W    = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  // HOLD_MAX of zero disables expiry; the count then parks at zero.
  localparam int unsigned LIM =
    (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
  localparam logic [CNT_W-1:0] LIM_C =
    CNT_W'(LIM);
  localparam logic ENABLED = (HOLD_MAX > 0);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max;

  assign at_max = (cnt_q == LIM_C);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = ENABLED & en_i & at_max;

endmodule

// File: rtl/rr_split_arbiter.sv
// Grant scheduler sharing the serial bus between two initiators and the split target.
// Ports: req_i_1/req_i_2/req_split/split_ack_in in; grants, sel, parked, timeout, busy out.
module rr_split_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 256,
  parameter int unsigned CNT_W    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i_1,
  input  logic       req_i_2,
  input  logic       req_split,
  input  logic       split_ack_in,
  output logic       grant_i_1,
  output logic       grant_i_2,
  output logic       grant_split,
  output logic [1:0] sel,
  output logic [1:0] parked,
  output logic       timeout,
  output logic       busy
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       rr_q;
  logic       rr_d;
  logic [1:0] parked_q;
  logic [1:0] parked_d;
  logic [1:0] lock_q;
  logic [1:0] lock_d;
  logic       to_q;
  logic       to_d;
  logic       g0_q;
  logic       g1_q;
  logic       gs_q;
  logic [1:0] sel_q;
  logic       busy_q;

  logic       expire;
  logic       elig0;
  logic       elig1;
  logic       in_grant;

  assign in_grant = (state_q != IDLE);

  // Every grant is entered from IDLE, so clearing in IDLE
  // gives a fresh count on each grant entry.
  arb_hold_timer #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!in_grant),
    .en_i     (in_grant),
    .expire_o (expire)
  );

  assign elig0 = req_i_1 & ~parked_q[0] & ~lock_q[0];
  assign elig1 = req_i_2 & ~parked_q[1] & ~lock_q[1];

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    parked_d = parked_q;
    lock_d   = lock_q;
    to_d     = 1'b0;
    if (!req_i_1) lock_d[0] = 1'b0;
    if (!req_i_2) lock_d[1] = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_split && |parked_q) begin
          state_d = GRANT_SPLIT;
        end else if (elig0 && elig1) begin
          state_d = rr_q ? GRANT_I1 : GRANT_I0;
        end else if (elig0) begin
          state_d = GRANT_I0;
        end else if (elig1) begin
          state_d = GRANT_I1;
        end
      end
      GRANT_I0: begin
        if (split_ack_in && parked_q == 2'b00)
          parked_d[0] = 1'b1;
        if (!req_i_1) begin
          state_d = IDLE;
          rr_d    = 1'b1;
        end else if (expire) begin
          state_d   = IDLE;
          to_d      = 1'b1;
          rr_d      = 1'b1;
          lock_d[0] = 1'b1;
        end
      end
      GRANT_I1: begin
        if (split_ack_in && parked_q == 2'b00)
          parked_d[1] = 1'b1;
        if (!req_i_2) begin
          state_d = IDLE;
          rr_d    = 1'b0;
        end else if (expire) begin
          state_d   = IDLE;
          to_d      = 1'b1;
          rr_d      = 1'b0;
          lock_d[1] = 1'b1;
        end
      end
      GRANT_SPLIT: begin
        // A watchdog revoke keeps parked so the
        // split target has to re-request.
        if (!req_split) begin
          state_d  = IDLE;
          parked_d = 2'b00;
        end else if (expire) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant/sel/busy are flopped from the next state
  // so the bus muxes see glitch-free controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      parked_q <= 2'b00;
      lock_q   <= 2'b00;
      to_q     <= 1'b0;
      g0_q     <= 1'b0;
      g1_q     <= 1'b0;
      gs_q     <= 1'b0;
      sel_q    <= SEL_NONE;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      parked_q <= parked_d;
      lock_q   <= lock_d;
      to_q     <= to_d;
      g0_q     <= (state_d == GRANT_I0);
      g1_q     <= (state_d == GRANT_I1);
      gs_q     <= (state_d == GRANT_SPLIT);
      sel_q    <= sel_of(state_d);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign grant_i_1   = g0_q;
  assign grant_i_2   = g1_q;
  assign grant_split = gs_q;
  assign sel         = sel_q;
  assign parked      = parked_q;
  assign timeout     = to_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rr_split_arbiter.sv
// Bench for rr_split_arbiter: directed scenarios plus random traffic
// checked every cycle against an owner-based behavioural model.
module tb_rr_split_arbiter;

  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_i_1 = 1'b0;
  logic       req_i_2 = 1'b0;
  logic       req_split = 1'b0;
  logic       split_ack_in = 1'b0;
  logic       grant_i_1;
  logic       grant_i_2;
  logic       grant_split;
  logic [1:0] sel;
  logic [1:0] parked;
  logic       timeout;
  logic       busy;

  rr_split_arbiter #(
    .HOLD_MAX (HOLD),
    .CNT_W    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i_1      (req_i_1),
    .req_i_2      (req_i_2),
    .req_split    (req_split),
    .split_ack_in (split_ack_in),
    .grant_i_1    (grant_i_1),
    .grant_i_2    (grant_i_2),
    .grant_split  (grant_split),
    .sel          (sel),
    .parked       (parked),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 none, 0/1 initiator, 2 split),
  // how many granted cycles it has used, and who is preferred.
  int       own = -1;
  int       used = 0;
  int       pref = 0;
  bit [1:0] pk = 2'b00;
  bit [1:0] lk = 2'b00;
  bit       to = 1'b0;

  task automatic model_step();
    int       nown;
    bit [1:0] npk;
    bit [1:0] nlk;
    bit       e0;
    bit       e1;
    bit       r;
    if (!rst_n) begin
      own = -1; used = 0; pref = 0;
      pk = 2'b00; lk = 2'b00; to = 1'b0;
      return;
    end
    to = 1'b0;
    nown = own;
    npk = pk;
    nlk = lk;
    if (!req_i_1) nlk[0] = 1'b0;
    if (!req_i_2) nlk[1] = 1'b0;
    if (own < 0) begin
      used = 0;
      e0 = req_i_1 && !pk[0] && !lk[0];
      e1 = req_i_2 && !pk[1] && !lk[1];
      if (req_split && pk != 2'b00) nown = 2;
      else if (e0 && e1) nown = pref;
      else if (e0) nown = 0;
      else if (e1) nown = 1;
    end else if (own < 2) begin
      r = (own == 0) ? req_i_1 : req_i_2;
      if (split_ack_in && pk == 2'b00) npk[own] = 1'b1;
      if (!r) begin
        nown = -1;
        pref = 1 - own;
      end else if (used + 1 >= HOLD) begin
        nown = -1;
        to = 1'b1;
        pref = 1 - own;
        nlk[own] = 1'b1;
      end else begin
        used++;
      end
    end else begin
      if (!req_split) begin
        nown = -1;
        npk = 2'b00;
      end else if (used + 1 >= HOLD) begin
        nown = -1;
        to = 1'b1;
      end else begin
        used++;
      end
    end
    own = nown;
    pk = npk;
    lk = nlk;
  endtask

  function automatic logic [8:0] exp_vec();
    logic [1:0] s;
    s = (own < 0) ? 2'd0 : 2'(own + 1);
    return {own == 0, own == 1, own == 2, s, pk, to, own >= 0};
  endfunction

  wire [8:0] dut_vec = {grant_i_1, grant_i_2, grant_split,
                        sel, parked, timeout, busy};

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle", 32'(dut_vec), 32'(exp_vec()));
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(dut_vec), 32'd0);
    rst_n = 1'b1;
    tick();

    // basic grant and release
    req_i_1 = 1'b1;
    tick();
    check("s1_grant", {grant_i_1, sel}, 3'b101);
    repeat (5) tick();
    req_i_1 = 1'b0;
    tick();
    check("s1_drop", grant_i_1, 1'b0);
    tick();

    // alternation with owner releases
    for (int i = 0; i < 3; i++) begin
      req_i_1 = 1'b1; req_i_2 = 1'b1;
      repeat (4) tick();
      req_i_1 = 1'b0;
      tick();
      req_i_1 = 1'b1;
      repeat (4) tick();
      req_i_2 = 1'b0;
      tick();
    end
    req_i_1 = 1'b0; req_i_2 = 1'b0;
    tick(); tick();

    // park I1 on a split, then split return
    req_i_2 = 1'b1;
    tick(); tick();
    split_ack_in = 1'b1;
    tick();
    split_ack_in = 1'b0;
    tick();
    req_i_2 = 1'b0;
    tick(); tick();
    check("s3_park", parked, 2'b10);
    req_i_2 = 1'b1;
    tick(); tick(); tick();
    check("s3_nogrant", grant_i_2, 1'b0);
    req_split = 1'b1;
    tick();
    check("s3_split", {grant_split, sel}, 3'b111);
    tick();
    req_split = 1'b0;
    tick();
    check("s3_unpark", parked, 2'b00);
    tick();
    check("s3_regrant", grant_i_2, 1'b1);
    req_i_2 = 1'b0;
    tick(); tick();

    // split return beats a same-cycle initiator request
    req_i_1 = 1'b1;
    tick();
    split_ack_in = 1'b1;
    tick();
    split_ack_in = 1'b0;
    req_i_1 = 1'b0;
    tick(); tick();
    check("s4_park", parked, 2'b01);
    req_split = 1'b1; req_i_2 = 1'b1;
    tick();
    check("s4_split_first", grant_split, 1'b1);
    tick();
    req_split = 1'b0;
    tick(); tick();
    check("s4_then_i1", grant_i_2, 1'b1);
    req_i_2 = 1'b0;
    tick(); tick();

    // watchdog revoke and lockout
    req_i_1 = 1'b1;
    tick();
    repeat (7) tick();
    check("s5_held8", grant_i_1, 1'b1);
    req_i_2 = 1'b1;
    tick();
    check("s5_revoke", {grant_i_1, timeout}, 2'b01);
    tick();
    check("s5_i1", grant_i_2, 1'b1);
    req_i_2 = 1'b0;
    tick(); tick();
    check("s5_lock", grant_i_1, 1'b0);
    req_i_1 = 1'b0;
    tick();
    req_i_1 = 1'b1;
    tick();
    check("s5_regrant", grant_i_1, 1'b1);
    req_i_1 = 1'b0;
    tick(); tick();

    // reset during a split grant
    req_i_1 = 1'b1;
    tick();
    split_ack_in = 1'b1;
    tick();
    split_ack_in = 1'b0;
    req_i_1 = 1'b0;
    tick(); tick();
    req_split = 1'b1;
    tick();
    check("s6_split", grant_split, 1'b1);
    rst_n = 1'b0;
    tick();
    check("s6_rst", 32'(dut_vec), 32'd0);
    rst_n = 1'b1;
    req_split = 1'b0;
    tick();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) req_i_1 = ~req_i_1;
      if ($urandom_range(0, 7) == 0) req_i_2 = ~req_i_2;
      if ($urandom_range(0, 9) == 0) req_split = ~req_split;
      split_ack_in = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
